// File: rtl/instr_encoder.sv
// instr_encoder: packs field-level instruction descriptors into 32-bit words
// and streams them into instruction memory from a programmable base address.
// Optional feature macro: ENC_PAD_NOP_EN appends three nop words after the
// final descriptor of a session.
module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [3:0]        in_fun,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words
);

  typedef enum logic [2:0] {IDLE, RUN, PAD, DONE, ERR} state_t;

  localparam logic [ADDR_W-1:0] ADDR_TOP = {ADDR_W{1'b1}};
  localparam logic [31:0]       NOP_WORD = 32'hFC00_0000;

  state_t            state;
  logic [ADDR_W-1:0] addr_cnt;
  logic              full;
  logic              last_seen;
  logic              legal;
  logic [31:0]       enc;
`ifdef ENC_PAD_NOP_EN
  logic [1:0]        pad_cnt;
`endif

  assign busy = (state != IDLE);

  // Opcode map: decide legality of the descriptor kind and pack its fields
  always_comb begin
    legal = 1'b1;
    enc   = '0;
    case (in_kind)
      4'd0:    enc = {6'b100000, in_rs, in_rt, in_imm};
      4'd1:    enc = {6'b100001, in_rs, in_rt, in_imm};
      4'd2:    enc = {6'b100010, in_rs, in_rt, in_imm};
      4'd3:    enc = {6'b100011, in_rs, in_rt, in_imm};
      4'd4:    enc = {6'b100100, in_rs, in_rt, in_imm};
      4'd5:    enc = {6'b100101, in_rs, in_rt, in_imm};
      4'd6:    enc = {6'b100110, in_rs, in_rt, in_imm};
      4'd7:    enc = {6'b100111, in_rs, in_rt, in_imm};
      4'd8:    enc = {6'b000000, in_target};
      4'd9:    enc = {6'b110000, in_rs, in_rt, in_rd, 5'b00000, 2'b00, in_fun};
      4'd10:   enc = NOP_WORD;
      default: legal = 1'b0;
    endcase
  end

  // Session FSM: handshake, write issue, address tracking and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      addr_cnt   <= '0;
      full       <= 1'b0;
      last_seen  <= 1'b0;
`ifdef ENC_PAD_NOP_EN
      pad_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          imem_we  <= 1'b0;
          done     <= 1'b0;
          in_ready <= 1'b0;
          if (start) begin
            state     <= RUN;
            addr_cnt  <= base_addr;
            err       <= 1'b0;
            full      <= 1'b0;
            last_seen <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        RUN: begin
          if (last_seen) begin
            imem_we  <= 1'b0;
            in_ready <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end else if (in_valid && in_ready) begin
            if (!legal || full) begin
              imem_we  <= 1'b0;
              in_ready <= 1'b0;
              err      <= 1'b1;
              state    <= ERR;
            end else begin
              imem_we    <= 1'b1;
              imem_addr  <= addr_cnt;
              imem_wdata <= enc;
              if (addr_cnt == ADDR_TOP) begin
                full <= 1'b1;
              end else begin
                addr_cnt <= addr_cnt + ADDR_W'(1);
              end
              in_ready <= !in_last && (addr_cnt != ADDR_TOP);
              if (in_last) begin
`ifdef ENC_PAD_NOP_EN
                state   <= PAD;
                pad_cnt <= 2'd3;
`else
                last_seen <= 1'b1;
`endif
              end
            end
          end else begin
            imem_we  <= 1'b0;
            in_ready <= 1'b1;
          end
        end
`ifdef ENC_PAD_NOP_EN
        PAD: begin
          in_ready <= 1'b0;
          if (pad_cnt == 2'd0) begin
            imem_we <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else if (full) begin
            imem_we <= 1'b0;
            err     <= 1'b1;
            state   <= ERR;
          end else begin
            imem_we    <= 1'b1;
            imem_addr  <= addr_cnt;
            imem_wdata <= NOP_WORD;
            pad_cnt    <= pad_cnt - 2'd1;
            if (addr_cnt == ADDR_TOP) begin
              full <= 1'b1;
            end else begin
              addr_cnt <= addr_cnt + ADDR_W'(1);
            end
          end
        end
`endif
        DONE: begin
          imem_we  <= 1'b0;
          in_ready <= 1'b0;
          done     <= 1'b0;
          state    <= IDLE;
        end
        ERR: begin
          imem_we  <= 1'b0;
          in_ready <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          imem_we  <= 1'b0;
          in_ready <= 1'b0;
          done     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // Word counter advances on the edge that closes each write cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      words <= '0;
    end else if (state == IDLE && start) begin
      words <= '0;
    end else if (imem_we) begin
      words <= words + (ADDR_W+1)'(1);
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed checks of the instruction encoder/loader,
// covering encoding, write timing, error and overflow handling.
module tb_instr_encoder;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  base_addr;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_kind;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [3:0]  in_fun;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        in_last;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [8:0]  words;

  int vectors;
  int miscompares;
  int write_count;

  instr_encoder #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_fun(in_fun),
    .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .err(err), .words(words)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tally every IMEM write seen at a clock edge
  always @(posedge clk) begin
    if (!rst && imem_we) write_count++;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] kind, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [4:0] rd,
                               input logic [3:0] fun, input logic [15:0] imm,
                               input logic [25:0] target, input logic last);
    in_kind   = kind;
    in_rs     = rs;
    in_rt     = rt;
    in_rd     = rd;
    in_fun    = fun;
    in_imm    = imm;
    in_target = target;
    in_last   = last;
    in_valid  = 1'b1;
  endtask

  task automatic beginSession(input logic [7:0] base);
    base_addr = base;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    write_count = 0;
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    applyStimulus(4'd10, '0, '0, '0, '0, '0, '0, 1'b0);
    tick();
    tick();
    checkOutput("rst_in_ready", in_ready, 1'b0);
    checkOutput("rst_imem_we", imem_we, 1'b0);
    checkOutput("rst_imem_addr", imem_addr, 8'h00);
    checkOutput("rst_imem_wdata", imem_wdata, 32'h0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_err", err, 1'b0);
    checkOutput("rst_words", words, 9'd0);

    rst = 1'b0;
    repeat (3) tick();
    checkOutput("idle_in_ready", in_ready, 1'b0);
    checkOutput("idle_imem_we", imem_we, 1'b0);
    checkOutput("idle_writes", write_count, 0);
    in_valid = 1'b0;

`ifdef ENC_PAD_NOP_EN
    beginSession(8'h00);
    applyStimulus(4'd10, '0, '0, '0, '0, '0, '0, 1'b1);
    tick();
    in_valid = 1'b0;
    checkOutput("pad_w0_we", imem_we, 1'b1);
    checkOutput("pad_w0_addr", imem_addr, 8'h00);
    checkOutput("pad_w0_data", imem_wdata, 32'hFC000000);
    checkOutput("pad_in_ready", in_ready, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      checkOutput("pad_we", imem_we, 1'b1);
      checkOutput("pad_addr", imem_addr, 32'(i));
      checkOutput("pad_data", imem_wdata, 32'hFC000000);
    end
    tick();
    checkOutput("pad_done", done, 1'b1);
    checkOutput("pad_done_we", imem_we, 1'b0);
    checkOutput("pad_words", words, 9'd4);
    tick();
    checkOutput("pad_done_clear", done, 1'b0);
    checkOutput("pad_busy_clear", busy, 1'b0);

    beginSession(8'hFE);
    applyStimulus(4'd4, 5'd1, 5'd2, '0, '0, 16'h0005, '0, 1'b1);
    tick();
    in_valid = 1'b0;
    checkOutput("padov_addr0", imem_addr, 8'hFE);
    checkOutput("padov_data0", imem_wdata, 32'h90220005);
    tick();
    checkOutput("padov_we1", imem_we, 1'b1);
    checkOutput("padov_addr1", imem_addr, 8'hFF);
    checkOutput("padov_data1", imem_wdata, 32'hFC000000);
    tick();
    checkOutput("padov_err", err, 1'b1);
    checkOutput("padov_we", imem_we, 1'b0);
    checkOutput("padov_done", done, 1'b0);
    checkOutput("padov_words", words, 9'd2);
    tick();
    checkOutput("padov_busy", busy, 1'b0);
    checkOutput("pad_total_writes", write_count, 6);
`else
    // Single addi, last
    beginSession(8'h10);
    checkOutput("a_busy", busy, 1'b1);
    checkOutput("a_in_ready", in_ready, 1'b1);
    applyStimulus(4'd4, 5'd1, 5'd2, '0, '0, 16'h0005, '0, 1'b1);
    tick();
    in_valid = 1'b0;
    checkOutput("a_we", imem_we, 1'b1);
    checkOutput("a_addr", imem_addr, 8'h10);
    checkOutput("a_data", imem_wdata, 32'h90220005);
    checkOutput("a_in_ready_low", in_ready, 1'b0);
    checkOutput("a_no_early_done", done, 1'b0);
    tick();
    checkOutput("a_we_off", imem_we, 1'b0);
    checkOutput("a_done", done, 1'b1);
    checkOutput("a_words", words, 9'd1);
    checkOutput("a_busy_done", busy, 1'b1);
    tick();
    checkOutput("a_done_clear", done, 1'b0);
    checkOutput("a_busy_clear", busy, 1'b0);

    // Back-to-back rtype, jump, lw
    beginSession(8'h20);
    applyStimulus(4'd9, 5'd3, 5'd4, 5'd5, 4'd1, '0, '0, 1'b0);
    tick();
    checkOutput("b_we0", imem_we, 1'b1);
    checkOutput("b_addr0", imem_addr, 8'h20);
    checkOutput("b_data0", imem_wdata, 32'hC0642801);
    applyStimulus(4'd8, '0, '0, '0, '0, '0, 26'h0000040, 1'b0);
    tick();
    checkOutput("b_we1", imem_we, 1'b1);
    checkOutput("b_addr1", imem_addr, 8'h21);
    checkOutput("b_data1", imem_wdata, 32'h00000040);
    applyStimulus(4'd0, 5'd0, 5'd6, '0, '0, 16'hFFFC, '0, 1'b1);
    tick();
    in_valid = 1'b0;
    checkOutput("b_we2", imem_we, 1'b1);
    checkOutput("b_addr2", imem_addr, 8'h22);
    checkOutput("b_data2", imem_wdata, 32'h8006FFFC);
    checkOutput("b_words_mid", words, 9'd2);
    tick();
    checkOutput("b_done", done, 1'b1);
    checkOutput("b_words", words, 9'd3);
    tick();
    checkOutput("b_busy_clear", busy, 1'b0);

    // Illegal kind mid-stream
    beginSession(8'h30);
    applyStimulus(4'd10, '0, '0, '0, '0, '0, '0, 1'b0);
    tick();
    checkOutput("c_nop_addr", imem_addr, 8'h30);
    checkOutput("c_nop_data", imem_wdata, 32'hFC000000);
    applyStimulus(4'd12, 5'd1, 5'd1, 5'd1, 4'd1, 16'h1111, '0, 1'b0);
    tick();
    in_valid = 1'b0;
    checkOutput("c_we", imem_we, 1'b0);
    checkOutput("c_err", err, 1'b1);
    checkOutput("c_done", done, 1'b0);
    checkOutput("c_words", words, 9'd1);
    tick();
    checkOutput("c_busy_drop", busy, 1'b0);
    checkOutput("c_err_sticky", err, 1'b1);
    checkOutput("c_no_done", done, 1'b0);
    beginSession(8'h40);
    checkOutput("c_err_cleared", err, 1'b0);
    applyStimulus(4'd6, 5'd7, 5'd8, '0, '0, 16'h00F0, '0, 1'b1);
    tick();
    in_valid = 1'b0;
    checkOutput("c_ori_addr", imem_addr, 8'h40);
    checkOutput("c_ori_data", imem_wdata, 32'h98E800F0);
    tick();
    tick();

    // Overflow at the top address
    beginSession(8'hFF);
    applyStimulus(4'd5, 5'd0, 5'd1, '0, '0, 16'h1234, '0, 1'b0);
    tick();
    checkOutput("d_we_top", imem_we, 1'b1);
    checkOutput("d_addr_top", imem_addr, 8'hFF);
    checkOutput("d_data_top", imem_wdata, 32'h94011234);
    checkOutput("d_ready_hold", in_ready, 1'b0);
    applyStimulus(4'd7, 5'd2, 5'd3, '0, '0, 16'h0001, '0, 1'b1);
    tick();
    checkOutput("d_we_gap", imem_we, 1'b0);
    checkOutput("d_ready_back", in_ready, 1'b1);
    checkOutput("d_err_pre", err, 1'b0);
    tick();
    in_valid = 1'b0;
    checkOutput("d_we_reject", imem_we, 1'b0);
    checkOutput("d_err", err, 1'b1);
    checkOutput("d_done", done, 1'b0);
    checkOutput("d_words", words, 9'd1);
    tick();
    checkOutput("d_busy_drop", busy, 1'b0);
    checkOutput("d_err_sticky", err, 1'b1);
    checkOutput("total_writes", write_count, 7);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential instruction encoder and loader: the writer-side counterpart of the decode-stage control unit. It accepts a stream of field-level instruction descriptors over a valid/ready handshake, packs each one into a 32-bit word using the core's opcode map, and writes the words consecutively into instruction memory from a programmable base address. It sits between the NoC program-load path and the IMEM write port, ahead of the fetch/decode pipeline.

## Interface
- ADDR_W, 8, IMEM word-address width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a load session (sampled only in IDLE)
- base_addr  in  ADDR_W  first IMEM word address of the session
- in_valid  in  1  descriptor valid
- in_ready  out  1  descriptor accepted when in_valid && in_ready
- in_kind  in  4  0 lw, 1 sw, 2 beq, 3 bne, 4 addi, 5 andi, 6 ori, 7 slti, 8 jump, 9 rtype, 10 nop, 11-15 illegal
- in_rs, in_rt, in_rd  in  5 each  register fields
- in_fun  in  4  ALU function for rtype
- in_imm  in  16  I-type immediate
- in_target  in  26  J-type target
- in_last  in  1  final descriptor of the session
- imem_we  out  1  IMEM write strobe
- imem_addr  out  ADDR_W  IMEM write address
- imem_wdata  out  32  encoded instruction
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at session end
- err  out  1  sticky error, cleared by the next accepted start
- words  out  ADDR_W+1  words written this session

## Operation
- Opcodes: lw 100000, sw 100001, beq 100010, bne 100011, addi 100100, andi 100101, ori 100110, slti 100111, jump 000000, rtype 110000, nop 111111.
- Formats: opcode in [31:26]. I-type: rs [25:21], rt [20:16], imm [15:0]. rtype: rs, rt, rd [15:11], [10:6]=0, fun [5:0]={2'b00,in_fun}. jump: target [25:0]. nop: [25:0]=0.
- FSM states: IDLE, RUN, PAD, DONE, ERR.
- IDLE: in_ready=0. start -> RUN; addr counter loads base_addr, words=0, err=0.
- RUN: in_ready=1 unless an output write is pending at the last address (see overflow). Each accepted legal beat is registered and written next cycle; counter increments after each write.
- Legal beat with in_last -> PAD (macro on) or DONE.
- Illegal in_kind accepted -> no write, err=1, -> ERR.
- Overflow: beat accepted while the next write address would wrap past 2^ADDR_W-1 after a prior write there -> no write, err=1, -> ERR. A write to the top address itself is legal; counter does not wrap into base.
- DONE: done=1 for one cycle, -> IDLE. ERR: one cycle, -> IDLE, err stays 1, done not asserted.
- start outside IDLE ignored. start and in_valid together in IDLE: beat not accepted that cycle.

## Timing
- Reset values: in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, busy 0, done 0, err 0, words 0; state IDLE.
- start at edge N -> busy=1 and in_ready=1 from N+1.
- Beat accepted at edge N -> imem_we=1 with address/data stable during cycle N+1; throughput one word per cycle.
- Final beat at edge N, no padding -> write during N+1, done during N+2, busy=0 at N+3.
- words updates on the same edge that ends each imem_we cycle.
- Reset mid-session aborts immediately; no further writes, partial IMEM contents left as written.

## Configuration
- ENC_PAD_NOP_EN defined: after the in_last write, PAD state emits three nop words (0xFC000000) at consecutive addresses, in_ready=0, then DONE; padding counts in words and obeys the overflow rule (overflow during PAD -> ERR).
- Undefined: PAD state absent; in_last goes straight to DONE.

## Test plan
- Reset then idle: all outputs 0, in_ready 0 with in_valid held high -> no imem_we.
- start base 0x10; addi rs=1 rt=2 imm=0x0005, last -> write addr 0x10 data 0x90220005, done pulse, words=1 (macro off).
- Back-to-back rtype rs=3 rt=4 rd=5 fun=1, jump target 0x0000040, lw rs=0 rt=6 imm=0xFFFC last -> 0xC0642801 @base, 0x00000040 @base+1, 0x8006FFFC @base+2, one write per cycle.
- in_kind=12 mid-stream -> no write for that beat, err=1, no done, busy drops; next start clears err.
- base 0xFF, two beats -> first written at 0xFF, second rejected with err=1; with ENC_PAD_NOP_EN, one beat at 0xFE last -> nop at 0xFF then err.
- ENC_PAD_NOP_EN, single nop last at base 0 -> 0xFC000000 at 0..3, words=4, done one cycle after last pad write.
